// File: rtl/lcd_seq_if.sv
// Bundle between the LCD sequencer and its environment: lcd_write byte handshake,
// panel reset/status, frame request and pixel stream.
interface lcd_seq_if;
    logic        wr_done;
    logic        en_write;
    logic [8:0]  lcd_data;
    logic        lcd_rst;
    logic        init_done;
    logic        frame_start;
    logic        frame_busy;
    logic        frame_done;
    logic [15:0] px_data;
    logic        px_valid;
    logic        px_ready;

    modport master (
        input  wr_done, frame_start, px_data, px_valid,
        output en_write, lcd_data, lcd_rst, init_done, frame_busy, frame_done, px_ready
    );

    modport slave (
        output wr_done, frame_start, px_data, px_valid,
        input  en_write, lcd_data, lcd_rst, init_done, frame_busy, frame_done, px_ready
    );
endinterface

// File: rtl/lcd_seq_ctrl.sv
// Panel sequencer for the lcd_write byte writer: hardware reset pulse, init table with
// delays, then full-screen window setup and one RGB565 frame per frame_start.
//
// state    | meaning
// RST_LOW  | lcd_rst held low
// RST_WAIT | lcd_rst high, waiting before first command
// INIT     | replaying init table (byte outstanding or delay running)
// READY    | idle, accepts frame_start
// WIN      | sending column/row window and RAMWR
// PIXEL    | streaming pixel bytes, high then low
module lcd_seq_ctrl #(
    parameter int RST_LOW_CYC  = 50_000,
    parameter int RST_WAIT_CYC = 6_000_000,
    parameter int MS_CYC       = 50_000,
    parameter int H_RES        = 240,
    parameter int V_RES        = 240
) (
    input  logic      sys_clk_50MHz,
    input  logic      sys_rst_n,
    lcd_seq_if.master bus
);
    typedef enum logic [2:0] {RST_LOW, RST_WAIT, INIT, READY, WIN, PIXEL} state_t;

    localparam logic [31:0] RST_LOW_TC  = 32'(RST_LOW_CYC - 1);
    localparam logic [31:0] RST_WAIT_TC = 32'(RST_WAIT_CYC - 1);
    localparam logic [31:0] MS_T        = 32'(MS_CYC);
    localparam logic [3:0]  INIT_LAST   = 4'd8;
    localparam logic [3:0]  WIN_LAST    = 4'd10;
    localparam logic [7:0]  H_LAST      = 8'(H_RES - 1);
    localparam logic [7:0]  V_LAST      = 8'(V_RES - 1);
    localparam logic [16:0] PIX_LAST    = 17'(H_RES * V_RES - 1);

    state_t      state, state_n;
    logic [31:0] timer, timer_n;
    logic [3:0]  idx, idx_n, adv_idx;
    logic        pend, pend_n, dly, dly_n, half, half_n;
    logic [16:0] pix, pix_n;
    logic [7:0]  px_lo, px_lo_n;
    logic        en_q, en_n, lcd_rst_q, lcd_rst_n;
    logic [8:0]  data_q, data_n, issue_data;
    logic        init_q, init_n, busy_q, busy_n, fdone_q, fdone_n, rdy_q, rdy_n;
    logic        issue, adv;
    logic [9:0]  entry;

    // bit 9 marks a delay entry whose low byte is the delay in ms; otherwise {dc, byte}
    function automatic logic [9:0] init_entry(input logic [3:0] i);
        case (i)
            4'd0:    init_entry = 10'h011;
            4'd1:    init_entry = 10'h278;
            4'd2:    init_entry = 10'h036;
            4'd3:    init_entry = 10'h100;
            4'd4:    init_entry = 10'h03A;
            4'd5:    init_entry = 10'h105;
            4'd6:    init_entry = 10'h021;
            4'd7:    init_entry = 10'h029;
            4'd8:    init_entry = 10'h214;
            default: init_entry = 10'h000;
        endcase
    endfunction

    function automatic logic [8:0] win_byte(input logic [3:0] i);
        case (i)
            4'd0:    win_byte = 9'h02A;
            4'd4:    win_byte = {1'b1, H_LAST};
            4'd5:    win_byte = 9'h02B;
            4'd9:    win_byte = {1'b1, V_LAST};
            4'd10:   win_byte = 9'h02C;
            default: win_byte = 9'h100;
        endcase
    endfunction

    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= RST_LOW;
            timer     <= RST_LOW_TC;
            idx       <= '0;
            pend      <= 1'b0;
            dly       <= 1'b0;
            half      <= 1'b0;
            pix       <= '0;
            px_lo     <= '0;
            en_q      <= 1'b0;
            data_q    <= '0;
            lcd_rst_q <= 1'b0;
            init_q    <= 1'b0;
            busy_q    <= 1'b0;
            fdone_q   <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            idx       <= idx_n;
            pend      <= pend_n;
            dly       <= dly_n;
            half      <= half_n;
            pix       <= pix_n;
            px_lo     <= px_lo_n;
            en_q      <= en_n;
            data_q    <= data_n;
            lcd_rst_q <= lcd_rst_n;
            init_q    <= init_n;
            busy_q    <= busy_n;
            fdone_q   <= fdone_n;
            rdy_q     <= rdy_n;
        end
    end

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        idx_n      = idx;
        pend_n     = pend;
        dly_n      = dly;
        half_n     = half;
        pix_n      = pix;
        px_lo_n    = px_lo;
        data_n     = data_q;
        lcd_rst_n  = lcd_rst_q;
        init_n     = init_q;
        busy_n     = busy_q;
        rdy_n      = rdy_q;
        en_n       = 1'b0;
        fdone_n    = 1'b0;
        issue      = 1'b0;
        issue_data = data_q;
        adv        = 1'b0;
        adv_idx    = idx;
        entry      = '0;

        case (state)
            RST_LOW:
                if (timer == '0) begin
                    state_n   = RST_WAIT;
                    lcd_rst_n = 1'b1;
                    timer_n   = RST_WAIT_TC;
                end else timer_n = timer - 32'd1;
            RST_WAIT:
                if (timer == '0) begin
                    state_n = INIT;
                    adv     = 1'b1;
                    adv_idx = 4'd0;
                end else timer_n = timer - 32'd1;
            INIT:
                if (dly) begin
                    if (timer == '0) begin
                        dly_n   = 1'b0;
                        adv     = 1'b1;
                        adv_idx = idx + 4'd1;
                    end else timer_n = timer - 32'd1;
                end else if (pend && bus.wr_done) begin
                    pend_n  = 1'b0;
                    adv     = 1'b1;
                    adv_idx = idx + 4'd1;
                end
            READY:
                if (bus.frame_start) begin
                    busy_n     = 1'b1;
                    state_n    = WIN;
                    idx_n      = 4'd0;
                    issue      = 1'b1;
                    issue_data = win_byte(4'd0);
                end
            WIN:
                if (pend && bus.wr_done) begin
                    pend_n = 1'b0;
                    if (idx == WIN_LAST) begin
                        state_n = PIXEL;
                        rdy_n   = 1'b1;
                    end else begin
                        idx_n      = idx + 4'd1;
                        issue      = 1'b1;
                        issue_data = win_byte(idx + 4'd1);
                    end
                end
            PIXEL:
                if (rdy_q && bus.px_valid) begin
                    px_lo_n    = bus.px_data[7:0];
                    rdy_n      = 1'b0;
                    half_n     = 1'b0;
                    issue      = 1'b1;
                    issue_data = {1'b1, bus.px_data[15:8]};
                end else if (pend && bus.wr_done) begin
                    pend_n = 1'b0;
                    if (!half) begin
                        half_n     = 1'b1;
                        issue      = 1'b1;
                        issue_data = {1'b1, px_lo};
                    end else if (pix == PIX_LAST) begin
                        pix_n   = '0;
                        fdone_n = 1'b1;
                        busy_n  = 1'b0;
                        state_n = READY;
                    end else begin
                        pix_n = pix + 17'd1;
                        rdy_n = 1'b1;
                    end
                end
            default: state_n = RST_LOW;
        endcase

        // start the next init entry: either a byte or a delay countdown
        if (adv) begin
            idx_n = adv_idx;
            if (adv_idx > INIT_LAST) begin
                init_n  = 1'b1;
                state_n = READY;
            end else begin
                entry = init_entry(adv_idx);
                if (entry[9]) begin
                    dly_n   = 1'b1;
                    timer_n = 32'(entry[7:0]) * MS_T;
                end else begin
                    issue      = 1'b1;
                    issue_data = entry[8:0];
                end
            end
        end

        if (issue) begin
            en_n   = 1'b1;
            data_n = issue_data;
            pend_n = 1'b1;
        end
    end

    assign bus.en_write   = en_q;
    assign bus.lcd_data   = data_q;
    assign bus.lcd_rst    = lcd_rst_q;
    assign bus.init_done  = init_q;
    assign bus.frame_busy = busy_q;
    assign bus.frame_done = fdone_q;
    assign bus.px_ready   = rdy_q;
endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Bench for lcd_seq_ctrl: a behavioural lcd_write responder plus a byte/handshake model
// derived from the panel init table, window rules and pixel stream.
module tb_lcd_seq_ctrl;
    localparam int RST_LOW_CYC  = 4;
    localparam int RST_WAIT_CYC = 8;
    localparam int MS_CYC       = 10;
    localparam int H_RES        = 2;
    localparam int V_RES        = 2;
    localparam int NPIX         = H_RES * V_RES;
    localparam int WR_LAT       = 5;
    localparam int WIN_BYTES    = 11;

    // init table: non-negative = {dc,byte}, negative = delay in ms
    localparam int INIT_TAB [9] = '{'h011, -120, 'h036, 'h100, 'h03A, 'h105, 'h021, 'h029, -20};
    localparam logic [8:0] INIT_LIT [7] = '{9'h011, 9'h036, 9'h100, 9'h03A, 9'h105, 9'h021, 9'h029};
    localparam logic [8:0] FRAME_LIT [19] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101,
                                              9'h02B, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02C,
                                              9'h112, 9'h134, 9'h1AB, 9'h1CD, 9'h10F, 9'h10F, 9'h1F0, 9'h1F0};
    localparam logic [15:0] PIX [4] = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hF0F0};

    logic clk = 1'b0, rst_n = 1'b0;
    logic wr_model = 1'b0, wr_spur = 1'b0;
    int   nchk = 0, nerr = 0;

    lcd_seq_if bus();
    assign bus.wr_done = wr_model | wr_spur;

    lcd_seq_ctrl #(.RST_LOW_CYC(RST_LOW_CYC), .RST_WAIT_CYC(RST_WAIT_CYC), .MS_CYC(MS_CYC),
                   .H_RES(H_RES), .V_RES(V_RES))
        dut (.sys_clk_50MHz(clk), .sys_rst_n(rst_n), .bus(bus));

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model + responder ----------------
    logic [8:0] exp_q[$], log_q[$], held;
    int   en_cyc[$], done_cyc[$];
    int   cyc = 0, fbytes = 0, fd_cnt = 0, init_rise = -1, cnt = 0;
    bit   busy_exp = 0, pxr_exp = 0, fd_exp = 0, prev_init = 0, wr_edge = 0, outst = 0;
    bit   busy_pre, pxr_pre;

    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!rst_n) begin
                wr_model = 0; wr_edge = 0; outst = 0; busy_exp = 0; pxr_exp = 0;
                fbytes = 0; prev_init = 0;
                exp_q.delete();
                foreach (INIT_TAB[i]) if (INIT_TAB[i] >= 0) exp_q.push_back(9'(INIT_TAB[i]));
                continue;
            end
            fd_exp   = 0;
            busy_pre = busy_exp;
            pxr_pre  = pxr_exp;
            if (bus.frame_start && prev_init && !busy_pre) begin
                busy_exp = 1;
                fbytes   = 0;
                exp_q.push_back(9'h02A); repeat (3) exp_q.push_back(9'h100);
                exp_q.push_back(9'h100 | 9'((H_RES - 1) & 255));
                exp_q.push_back(9'h02B); repeat (3) exp_q.push_back(9'h100);
                exp_q.push_back(9'h100 | 9'((V_RES - 1) & 255));
                exp_q.push_back(9'h02C);
            end
            if (bus.px_valid && pxr_pre) begin
                exp_q.push_back({1'b1, bus.px_data[15:8]});
                exp_q.push_back({1'b1, bus.px_data[7:0]});
                pxr_exp = 0;
            end
            if (wr_edge && busy_pre) begin
                fbytes++;
                if (fbytes == WIN_BYTES) pxr_exp = 1;
                else if (fbytes > WIN_BYTES && (fbytes - WIN_BYTES) % 2 == 0) begin
                    if (fbytes == WIN_BYTES + 2 * NPIX) begin fd_exp = 1; busy_exp = 0; end
                    else pxr_exp = 1;
                end
            end
            wr_edge = 0;
            wr_model = 0;
            chk("frame_busy", bus.frame_busy, busy_exp);
            chk("frame_done", bus.frame_done, fd_exp);
            chk("px_ready", bus.px_ready, pxr_exp);
            if (bus.frame_done) fd_cnt++;
            if (prev_init) chk("init_done_sticky", bus.init_done, 1);
            if (bus.init_done && !prev_init) init_rise = cyc;
            prev_init = bus.init_done;
            if (bus.en_write) begin
                chk("one_outstanding", outst, 0);
                if (exp_q.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL byte_extra: got 0x%03h, want no byte at %0t", bus.lcd_data, $time);
                end else chk("byte", bus.lcd_data, exp_q.pop_front());
                log_q.push_back(bus.lcd_data);
                en_cyc.push_back(cyc);
                outst = 1; cnt = WR_LAT; held = bus.lcd_data;
            end else if (outst) begin
                chk("data_hold", bus.lcd_data, held);
                cnt--;
                if (cnt == 0) begin
                    wr_model = 1; wr_edge = 1; outst = 0;
                    done_cyc.push_back(cyc);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic bit ab_seen(input int base);
        for (int j = base; j < log_q.size(); j++) if (log_q[j] == 9'h1AB) return 1;
        return 0;
    endfunction

    task automatic assert_rst();
        @(negedge clk); rst_n = 0;
        @(posedge clk); #1;
        chk("rst_en_write", bus.en_write, 0);
        chk("rst_lcd_data", bus.lcd_data, 0);
        chk("rst_lcd_rst", bus.lcd_rst, 0);
        chk("rst_init_done", bus.init_done, 0);
        chk("rst_frame_busy", bus.frame_busy, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_px_ready", bus.px_ready, 0);
    endtask

    task automatic release_rst();
        @(negedge clk); rst_n = 1;
        for (int k = 1; k <= RST_LOW_CYC + RST_WAIT_CYC; k++) begin
            @(posedge clk); #1;
            chk("lcd_rst_timing", bus.lcd_rst, 32'(k >= RST_LOW_CYC));
            chk("first_en_timing", bus.en_write, 32'(k == RST_LOW_CYC + RST_WAIT_CYC));
        end
        chk("first_byte", bus.lcd_data, 9'h011);
    endtask

    task automatic pulse_fs();
        @(negedge clk); bus.frame_start = 1;
        @(negedge clk); bus.frame_start = 0;
    endtask

    task automatic pulse_spur();
        @(negedge clk); wr_spur = 1;
        @(negedge clk); wr_spur = 0;
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!bus.init_done && n < 5000) begin @(negedge clk); n++; end
        chk(name, bus.init_done, 1);
    endtask

    task automatic stall_gap();
        int n = 0, en_cnt = 0, lo_cnt = 0;
        bus.px_valid = 0;
        while (!bus.px_ready && n < 200) begin @(negedge clk); n++; end
        chk("stall_ready_up", bus.px_ready, 1);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            wr_spur = (c == 100);
            bus.frame_start = (c == 200);
            if (bus.en_write) en_cnt++;
            if (!bus.px_ready) lo_cnt++;
        end
        wr_spur = 0; bus.frame_start = 0;
        chk("stall_no_en_write", en_cnt, 0);
        chk("stall_px_ready_low_cycles", lo_cnt, 0);
        bus.px_valid = 1;
    endtask

    task automatic feed(input bit stall, input bit abort_ab, input int base);
        int i = 0, n = 0;
        bit took = 0;
        bus.px_valid = 1; bus.px_data = PIX[0];
        while (i < NPIX && n < 5000) begin
            @(negedge clk); n++;
            if (took) begin
                i++;
                bus.px_data  = PIX[i % NPIX];
                bus.px_valid = (i < NPIX);
                if (stall && i == 2) stall_gap();
            end
            if (abort_ab && ab_seen(base)) break;
            took = bus.px_valid && bus.px_ready;
        end
        bus.px_valid = 0;
        if (abort_ab) chk("saw_1AB", 32'(ab_seen(base)), 1);
        else chk("pixels_taken", i, NPIX);
    endtask

    initial begin
        int base, rbase, n;
        bus.frame_start = 0; bus.px_valid = 0; bus.px_data = '0;

        assert_rst();
        release_rst();

        // frame_start and a stray wr_done during the 120 ms delay
        n = 0;
        while (done_cyc.size() < 1 && n < 100) begin @(negedge clk); n++; end
        chk("first_wr_done", 32'(done_cyc.size() >= 1), 1);
        repeat (50) @(negedge clk);
        pulse_fs();
        pulse_spur();
        wait_init("init_done_first");

        if (done_cyc.size() >= 7 && en_cyc.size() >= 7) begin
            chk("gap_after_11", 32'(en_cyc[1] - done_cyc[0] >= -INIT_TAB[1] * MS_CYC), 1);
            chk("init_done_after_29", 32'(init_rise - done_cyc[6] >= -INIT_TAB[8] * MS_CYC), 1);
        end else chk("init_log_len", done_cyc.size(), 7);
        chk("init_log_size", log_q.size(), 7);
        for (int j = 0; j < 7 && j < log_q.size(); j++) chk("init_lit", log_q[j], INIT_LIT[j]);
        chk("init_queue_drained", exp_q.size(), 0);

        // frame 1 with a pixel stall
        pulse_spur();
        base = log_q.size();
        pulse_fs();
        feed(1'b1, 1'b0, base);
        n = 0;
        while (fd_cnt < 1 && n < 2000) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        chk("frame_done_count", fd_cnt, 1);
        chk("frame_len", log_q.size() - base, 19);
        for (int j = 0; j < 19 && base + j < log_q.size(); j++) chk("frame_lit", log_q[base + j], FRAME_LIT[j]);
        chk("frame_queue_drained", exp_q.size(), 0);

        // frame 2 interrupted by reset after the 0xAB byte
        base = log_q.size();
        pulse_fs();
        feed(1'b0, 1'b1, base);
        repeat (2) @(negedge clk);
        assert_rst();
        rbase = log_q.size();
        release_rst();
        wait_init("init_done_replay");
        chk("replay_len", log_q.size() - rbase, 7);
        for (int j = 0; j < 7 && rbase + j < log_q.size(); j++) chk("replay_lit", log_q[rbase + j], INIT_LIT[j]);
        chk("replay_queue_drained", exp_q.size(), 0);
        chk("frame_done_total", fd_cnt, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", nerr, nchk);
        $fatal(1);
    end
endmodule
